winograd_psum_accum: RTL and testbench

Parametrised partial-sum accumulator that sits between the Winograd PE array outputs and the write-back/pooling path. It replaces the fixed 1k inter-data FIFO plus per-PE pool blocks with one block that holds per-tile partial sums across input-channel passes and adds bias on the first pass. It applies optional ReLU and saturation on the last pass, and emits both unpooled and tile-max-pooled results. It adds what the previous core lacked: depth/width/channel generality, hazard forwarding, saturating arithmetic and overflow/underflow detection.

---
 rtl/winograd_psum_accum.sv | 203 ++++++++++++++++++++
 tb/tb_winograd_psum_accum.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_psum_accum.sv
// Partial-sum accumulator for the Winograd PE array: holds per-tile psums across
// input-channel passes, adds bias on the first pass, emits clamped/ReLU'd and tile-max-pooled results.
module winograd_psum_accum #(
   parameter int X_PE        = 16,
   parameter int RESULT_SIZE = 2,
   parameter int PE_BIT      = 20,
   parameter int BIAS_BIT    = 20,
   parameter int PSUM_BIT    = 28,
   parameter int OUT_BIT     = 24,
   parameter int DEPTH       = 1024
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              in_valid,
   input  logic                                              pass_first,
   input  logic                                              pass_last,
   input  logic                                              relu_en,
   input  logic [PE_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0]    pe_result,
   input  logic [BIAS_BIT*X_PE-1:0]                          bias,
   input  logic                                              clr_err,
   output logic                                              out_valid,
   output logic [OUT_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0]   result_unpool,
   output logic [OUT_BIT*X_PE-1:0]                           result_pool,
   output logic                                              full,
   output logic                                              empty,
   output logic [$clog2(DEPTH):0]                            count,
   output logic                                              err_overflow,
   output logic                                              err_underflow
);

   localparam int TILE = RESULT_SIZE * RESULT_SIZE;
   localparam int NEL  = TILE * X_PE;
   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = PSUM_BIT * NEL;
   localparam logic [PSUM_BIT-1:0] OUT_MAX_P = {{(PSUM_BIT-OUT_BIT+1){1'b0}}, {(OUT_BIT-1){1'b1}}};
   localparam logic [PSUM_BIT-1:0] OUT_MIN_P = {{(PSUM_BIT-OUT_BIT+1){1'b1}}, {(OUT_BIT-1){1'b0}}};

   function automatic logic [PSUM_BIT-1:0] satAdd(input logic [PSUM_BIT-1:0] a,
                                                  input logic [PSUM_BIT-1:0] b);
      logic [PSUM_BIT:0] s;
      s = {a[PSUM_BIT-1], a} + {b[PSUM_BIT-1], b};
      if (s[PSUM_BIT] != s[PSUM_BIT-1])
         satAdd = s[PSUM_BIT] ? {1'b1, {(PSUM_BIT-1){1'b0}}} : {1'b0, {(PSUM_BIT-1){1'b1}}};
      else
         satAdd = s[PSUM_BIT-1:0];
   endfunction

   function automatic logic [OUT_BIT-1:0] emitElem(input logic [PSUM_BIT-1:0] v, input logic relu);
      logic [PSUM_BIT-1:0] r;
      r = (relu && v[PSUM_BIT-1]) ? '0 : v;
      if ($signed(r) > $signed(OUT_MAX_P))
         emitElem = OUT_MAX_P[OUT_BIT-1:0];
      else if ($signed(r) < $signed(OUT_MIN_P))
         emitElem = OUT_MIN_P[OUT_BIT-1:0];
      else
         emitElem = r[OUT_BIT-1:0];
   endfunction

   logic [PW-1:0]              mem [DEPTH];
   logic [AW-1:0]              wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [AW:0]                count_q, count_d;
   logic                       errOvf_q, errOvf_d, errUnf_q, errUnf_d;
   logic                       isFirst, isMid, isLast, isSingle;
   logic                       doRead, doAlloc, doFree, doWrite, doEmit;
   logic                       wr1_q, emit1_q, useBias1_q, relu1_q;
   logic [AW-1:0]              waddr1_q;
   logic [PE_BIT*NEL-1:0]      pe1_q;
   logic [BIAS_BIT*X_PE-1:0]   bias1_q;
   logic [PW-1:0]              rdData1_q, sum1_d;
   logic                       wr2_q, emit2_q, relu2_q;
   logic [AW-1:0]              waddr2_q;
   logic [PW-1:0]              sum2_q;
   logic                       outValid_q;
   logic [OUT_BIT*NEL-1:0]     unpool_q, unpool_d;
   logic [OUT_BIT*X_PE-1:0]    pool_q, pool_d;
   logic [PE_BIT-1:0]          peElem;
   logic [BIAS_BIT-1:0]        biasElem;
   logic [PSUM_BIT-1:0]        addend;
   logic [OUT_BIT-1:0]         best, cand;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

   // Classify the beat and decide which buffer operations it performs or whether it is dropped.
   always_comb begin
      isFirst  = in_valid &  pass_first & ~pass_last;
      isMid    = in_valid & ~pass_first & ~pass_last;
      isLast   = in_valid & ~pass_first &  pass_last;
      isSingle = in_valid &  pass_first &  pass_last;
      doAlloc  = isFirst & ~full;
      doRead   = (isMid | isLast) & ~empty;
      doFree   = isLast & ~empty;
      doWrite  = doAlloc | (isMid & ~empty);
      doEmit   = isSingle | doFree;
      wrPtr_d  = doWrite ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_d  = doRead  ? rdPtr_q + AW'(1) : rdPtr_q;
      count_d  = count_q;
      if (doAlloc)
         count_d = count_q + (AW+1)'(1);
      else if (doFree)
         count_d = count_q - (AW+1)'(1);
      errOvf_d = clr_err ? 1'b0 : (errOvf_q | (isFirst & full));
      errUnf_d = clr_err ? 1'b0 : (errUnf_q | ((isMid | isLast) & empty));
   end

   // Stage-1 saturating add: the addend is either the bias or the forwarded/stored psum.
   always_comb begin
      sum1_d   = '0;
      peElem   = '0;
      biasElem = '0;
      addend   = '0;
      for (int i = 0; i < NEL; i++) begin
         peElem   = pe1_q[i*PE_BIT +: PE_BIT];
         biasElem = bias1_q[(i/TILE)*BIAS_BIT +: BIAS_BIT];
         addend   = useBias1_q ? {{(PSUM_BIT-BIAS_BIT){biasElem[BIAS_BIT-1]}}, biasElem}
                               : rdData1_q[i*PSUM_BIT +: PSUM_BIT];
         sum1_d[i*PSUM_BIT +: PSUM_BIT] =
            satAdd(addend, {{(PSUM_BIT-PE_BIT){peElem[PE_BIT-1]}}, peElem});
      end
   end

   always_comb begin
      unpool_d = '0;
      pool_d   = '0;
      best     = '0;
      cand     = '0;
      for (int i = 0; i < NEL; i++)
         unpool_d[i*OUT_BIT +: OUT_BIT] = emitElem(sum2_q[i*PSUM_BIT +: PSUM_BIT], relu2_q);
      for (int c = 0; c < X_PE; c++) begin
         best = unpool_d[(c*TILE)*OUT_BIT +: OUT_BIT];
         for (int e = 1; e < TILE; e++) begin
            cand = unpool_d[(c*TILE+e)*OUT_BIT +: OUT_BIT];
            if ($signed(cand) > $signed(best))
               best = cand;
         end
         pool_d[c*OUT_BIT +: OUT_BIT] = best;
      end
   end

   // Control state and pipeline valids; a reset discards every in-flight beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         errOvf_q   <= 1'b0;
         errUnf_q   <= 1'b0;
         wr1_q      <= 1'b0;
         emit1_q    <= 1'b0;
         wr2_q      <= 1'b0;
         emit2_q    <= 1'b0;
         outValid_q <= 1'b0;
         unpool_q   <= '0;
         pool_q     <= '0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         errOvf_q   <= errOvf_d;
         errUnf_q   <= errUnf_d;
         wr1_q      <= doWrite;
         emit1_q    <= doEmit;
         wr2_q      <= wr1_q;
         emit2_q    <= emit1_q;
         outValid_q <= emit2_q;
         if (emit2_q) begin
            unpool_q <= unpool_d;
            pool_q   <= pool_d;
         end
      end
   end

   // The read bypasses any write still in flight; the beat in stage 1 is younger and wins.
   always_ff @(posedge clk) begin
      useBias1_q <= pass_first;
      relu1_q    <= relu_en;
      waddr1_q   <= wrPtr_q;
      pe1_q      <= pe_result;
      bias1_q    <= bias;
      if (wr1_q && (waddr1_q == rdPtr_q))
         rdData1_q <= sum1_d;
      else if (wr2_q && (waddr2_q == rdPtr_q))
         rdData1_q <= sum2_q;
      else
         rdData1_q <= mem[rdPtr_q];
      relu2_q    <= relu1_q;
      waddr2_q   <= waddr1_q;
      sum2_q     <= sum1_d;
   end

   always_ff @(posedge clk) begin
      if (wr2_q)
         mem[waddr2_q] <= sum2_q;
   end

   assign out_valid     = outValid_q;
   assign result_unpool = unpool_q;
   assign result_pool   = pool_q;
   assign count         = count_q;
   assign err_overflow  = errOvf_q;
   assign err_underflow = errUnf_q;

endmodule

// File: tb/tb_winograd_psum_accum.sv
// Scoreboard bench for winograd_psum_accum: a tile-queue reference model predicts outputs and
// status; a negedge monitor pops and compares them.
module tb_winograd_psum_accum;

   localparam int XP   = 2;
   localparam int RS   = 2;
   localparam int PEB  = 20;
   localparam int BB   = 20;
   localparam int PSB  = 28;
   localparam int OB   = 24;
   localparam int DP   = 4;
   localparam int TILE = RS * RS;
   localparam int NEL  = TILE * XP;
   localparam int CW   = $clog2(DP) + 1;
   localparam longint PMAX = (longint'(1) << (PSB-1)) - 1;
   localparam longint PMIN = -(longint'(1) << (PSB-1));
   localparam longint OMAX = (longint'(1) << (OB-1)) - 1;
   localparam longint OMIN = -(longint'(1) << (OB-1));

   typedef struct packed {
      logic [NEL*OB-1:0] unp;
      logic [XP*OB-1:0]  pool;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic                in_valid, pass_first, pass_last, relu_en, clr_err;
   logic [NEL*PEB-1:0]  pe_result;
   logic [XP*BB-1:0]    bias;
   logic                out_valid;
   logic [NEL*OB-1:0]   result_unpool;
   logic [XP*OB-1:0]    result_pool;
   logic                full, empty;
   logic [CW-1:0]       count;
   logic                err_overflow, err_underflow;

   logic [NEL*PSB-1:0]  bufQ[$];
   exp_t                outQ[$];
   logic [CW+3:0]       statQ[$];
   bit                  mOvf, mUnf;
   bit                  finalReq, finalDone;
   int                  total, bad;
   exp_t                gotExp;
   logic [CW+3:0]       gotStat;

   winograd_psum_accum #(
      .X_PE(XP), .RESULT_SIZE(RS), .PE_BIT(PEB), .BIAS_BIT(BB),
      .PSUM_BIT(PSB), .OUT_BIT(OB), .DEPTH(DP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pass_first(pass_first),
      .pass_last(pass_last), .relu_en(relu_en), .pe_result(pe_result), .bias(bias),
      .clr_err(clr_err), .out_valid(out_valid), .result_unpool(result_unpool),
      .result_pool(result_pool), .full(full), .empty(empty), .count(count),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint sx(input logic [63:0] raw, input int w);
      longint t;
      t = longint'(raw << (64 - w));
      return t >>> (64 - w);
   endfunction

   function automatic longint clampL(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic [NEL*PEB-1:0] peAll(input int v);
      logic [NEL*PEB-1:0] r;
      for (int e = 0; e < NEL; e++) r[e*PEB +: PEB] = PEB'(v);
      return r;
   endfunction

   function automatic logic [XP*BB-1:0] biasAll(input int v);
      logic [XP*BB-1:0] r;
      for (int c = 0; c < XP; c++) r[c*BB +: BB] = BB'(v);
      return r;
   endfunction

   function automatic logic [NEL*PEB-1:0] peMixed();
      logic [NEL*PEB-1:0] r;
      for (int e = 0; e < NEL; e++) r[e*PEB +: PEB] = (e % 2 == 0) ? PEB'(524287) : PEB'(-524288);
      return r;
   endfunction

   // Reference emit: ReLU, clamp to the output range, channel max.
   task automatic modelEmit(input logic [NEL*PSB-1:0] t, input bit relu);
      exp_t   x;
      longint v;
      longint mx [XP];
      logic [63:0] vb;
      for (int c = 0; c < XP; c++) mx[c] = OMIN - 1;
      for (int e = 0; e < NEL; e++) begin
         v = sx(64'(t[e*PSB +: PSB]), PSB);
         if (relu && v < 0) v = 0;
         v = clampL(v, OMIN, OMAX);
         vb = 64'(v);
         x.unp[e*OB +: OB] = vb[OB-1:0];
         if (v > mx[e/TILE]) mx[e/TILE] = v;
      end
      for (int c = 0; c < XP; c++) begin
         vb = 64'(mx[c]);
         x.pool[c*OB +: OB] = vb[OB-1:0];
      end
      outQ.push_back(x);
   endtask

   // Unpipelined reference: buffer modelled as a FIFO of tiles.
   task automatic modelBeat(input bit v, input bit f, input bit l, input bit relu, input bit clr,
                            input logic [NEL*PEB-1:0] pe, input logic [XP*BB-1:0] b);
      logic [NEL*PSB-1:0] base, nt;
      longint s;
      logic [63:0] sb;
      bit haveTile;
      haveTile = 1'b0;
      base = '0;
      if (v) begin
         if (f && !l && bufQ.size() == DP) mOvf = 1'b1;
         else if (!f && bufQ.size() == 0) mUnf = 1'b1;
         else begin
            if (!f) base = bufQ.pop_front();
            for (int e = 0; e < NEL; e++) begin
               s = sx(64'(pe[e*PEB +: PEB]), PEB) +
                   (f ? sx(64'(b[(e/TILE)*BB +: BB]), BB) : sx(64'(base[e*PSB +: PSB]), PSB));
               sb = 64'(clampL(s, PMIN, PMAX));
               nt[e*PSB +: PSB] = sb[PSB-1:0];
            end
            haveTile = 1'b1;
         end
      end
      if (haveTile) begin
         if (l) modelEmit(nt, relu);
         else bufQ.push_back(nt);
      end
      if (clr) begin
         mOvf = 1'b0;
         mUnf = 1'b0;
      end
   endtask

   task automatic applyStimulus(input bit v, input bit f, input bit l, input bit relu, input bit clr,
                                input logic [NEL*PEB-1:0] pe, input logic [XP*BB-1:0] b);
      in_valid   = v;
      pass_first = f;
      pass_last  = l;
      relu_en    = relu;
      clr_err    = clr;
      pe_result  = pe;
      bias       = b;
      @(posedge clk);
      #1;
      modelBeat(v, f, l, relu, clr, pe, b);
      statQ.push_back({CW'(bufQ.size()), bufQ.size() == DP, bufQ.size() == 0, mOvf, mUnf});
      in_valid = 1'b0;
      clr_err  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every compare lives here so one process owns the counters.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("reset_state",
            {out_valid, result_unpool, result_pool, full, empty, count, err_overflow, err_underflow},
            {1'b0, {(NEL*OB){1'b0}}, {(XP*OB){1'b0}}, 1'b0, 1'b1, {CW{1'b0}}, 2'b00});
      end else begin
         if (statQ.size() > 0) begin
            gotStat = statQ.pop_front();
            checkOutput("status", {count, full, empty, err_overflow, err_underflow}, gotStat);
         end
         if (out_valid) begin
            if (outQ.size() == 0) checkOutput("spurious_out_valid", out_valid, 1'b0);
            else begin
               gotExp = outQ.pop_front();
               checkOutput("unpool", result_unpool, gotExp.unp);
               checkOutput("pool", result_pool, gotExp.pool);
            end
         end
         if (finalReq && !finalDone) begin
            checkOutput("pending_outputs", outQ.size(), 0);
            finalDone = 1'b1;
         end
      end
   end

   initial begin
      int r;
      logic [NEL*PEB-1:0] pv;
      int sv;
      total = 0; bad = 0; finalReq = 0; finalDone = 0; mOvf = 0; mUnf = 0;
      in_valid = 0; pass_first = 0; pass_last = 0; relu_en = 0; clr_err = 0;
      pe_result = '0; bias = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(1, 1, 1, 0, 0, peAll(100), biasAll(-30));
      idle(4);

      for (int t = 0; t < 4; t++) applyStimulus(1, 1, 0, 0, 0, peAll(1), biasAll(2));
      for (int t = 0; t < 4; t++) applyStimulus(1, 0, 0, 0, 0, peAll(3), '0);
      for (int t = 0; t < 4; t++) applyStimulus(1, 0, 1, 0, 0, peAll(4), '0);
      idle(3);

      applyStimulus(1, 1, 0, 0, 0, peAll(5), biasAll(1));
      applyStimulus(1, 0, 0, 0, 0, peAll(7), '0);
      applyStimulus(1, 0, 1, 0, 0, peAll(9), '0);
      applyStimulus(1, 1, 0, 0, 0, peAll(-8), biasAll(3));
      idle(1);
      applyStimulus(1, 0, 0, 0, 0, peAll(11), '0);
      idle(1);
      applyStimulus(1, 0, 1, 1, 0, peAll(-20), '0);
      idle(3);

      applyStimulus(1, 1, 0, 0, 0, '0, '0);
      for (int t = 0; t < 300; t++) applyStimulus(1, 0, 0, 0, 0, peMixed(), '0);
      applyStimulus(1, 0, 1, 0, 0, '0, '0);
      applyStimulus(1, 1, 0, 0, 0, '0, '0);
      for (int t = 0; t < 40; t++) applyStimulus(1, 0, 0, 0, 0, peMixed(), '0);
      applyStimulus(1, 0, 1, 1, 0, '0, '0);
      idle(3);

      for (int t = 0; t < 5; t++) applyStimulus(1, 1, 0, 0, 0, peAll(t), biasAll(1));
      for (int t = 0; t < 4; t++) applyStimulus(1, 0, 1, 0, 0, peAll(2), '0);
      applyStimulus(1, 0, 1, 0, 0, peAll(2), '0);
      idle(3);
      applyStimulus(0, 0, 0, 0, 1, '0, '0);
      idle(1);

      applyStimulus(1, 1, 0, 0, 0, peAll(3), '0);
      applyStimulus(1, 0, 1, 0, 0, peAll(1), '0);
      rst_n = 1'b0;
      bufQ.delete(); outQ.delete(); statQ.delete();
      mOvf = 0; mUnf = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1, 1, 1, 0, 0, peAll(10), biasAll(5));
      idle(4);

      for (int t = 0; t < 400; t++) begin
         r = $urandom_range(0, 99);
         for (int e = 0; e < NEL; e++) begin
            if ($urandom_range(0, 1) == 1) pv[e*PEB +: PEB] = PEB'($urandom);
            else begin
               sv = $urandom_range(0, 100) - 50;
               pv[e*PEB +: PEB] = PEB'(sv);
            end
         end
         if (r < 15)      applyStimulus(0, 0, 0, 0, ($urandom_range(0, 9) == 0), pv, '0);
         else if (r < 42) applyStimulus(1, 1, 0, 0, 0, pv, {BB'($urandom), BB'($urandom)});
         else if (r < 62) applyStimulus(1, 0, 0, 0, 0, pv, '0);
         else if (r < 88) applyStimulus(1, 0, 1, $urandom_range(0, 1), ($urandom_range(0, 19) == 0), pv, '0);
         else             applyStimulus(1, 1, 1, $urandom_range(0, 1), 0, pv, {BB'($urandom), BB'($urandom)});
      end
      idle(6);

      finalReq = 1'b1;
      for (int w = 0; w < 10 && !finalDone; w++) @(posedge clk);
      if (!finalDone) begin
         $display("[TB] FAIL final_check actual=0 expected=1");
         $fatal(1, "[TB] monitor did not complete final check");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
